ifu: RTL and testbench

Instruction fetch unit for the single-cycle RV32 core. Sits directly upstream of the core: takes the core's current `pc`, fetches the 32-bit instruction word from instruction memory over a valid/ready read channel with variable latency, and presents it to the core as `cmd` for exactly one cycle. In that cycle it pulses `pc_wen` so the core's PC advances to `dnpc`. Outside that cycle `cmd` is forced to NOP, so the core's unconditional register-file writes are harmless while a fetch is pending.

---
 rtl/ifu_pkg.sv | 15 +
 rtl/ifu.sv | 100 ++++++++++
 tb/tb_ifu.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction fetch unit.
package ifu_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StAddr,
    StWait,
    StExec,
    StErr
  } state_e;

  localparam logic [31:0] INST_NOP  = 32'h0000_0013;
  localparam logic [1:0]  RESP_OKAY = 2'b00;

endpackage

// File: rtl/ifu.sv
// Instruction fetch unit: fetches one word per core PC over a valid/ready read channel
// and presents it to the core for a single cycle, NOP otherwise.
module ifu
  import ifu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc,
  output logic [31:0] cmd,
  output logic        cmd_valid,
  output logic        pc_wen,
  output logic        arvalid,
  output logic [31:0] araddr,
  input  logic        arready,
  input  logic        rvalid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  output logic        rready,
  output logic        fetch_err,
  output logic [31:0] inst_cnt
);

  state_e      state_q;
  logic [31:0] cmd_q;
  logic [31:0] araddr_q;
  logic        ar_pend_q;
  logic [31:0] tmo_q;
  logic [31:0] inst_cnt_q;

  logic        pc_ok;
  logic [31:0] tmo_next;
  logic        tmo_hit;

  assign pc_ok    = (pc[1:0] == 2'b00);
  assign tmo_next = tmo_q + 32'd1;
  assign tmo_hit  = (TIMEOUT != 0) && (tmo_next == 32'(TIMEOUT));

  // The core PC changes on the edge that ends EXEC, so the first ADDR cycle presents the
  // live pc; once the request stalls, the captured copy keeps the address stable.
  assign araddr    = (state_q == StAddr && !ar_pend_q) ? pc : araddr_q;
  assign arvalid   = (state_q == StAddr) && (ar_pend_q || pc_ok);
  assign rready    = (state_q == StWait);
  assign cmd_valid = (state_q == StExec);
  assign pc_wen    = cmd_valid;
  assign cmd       = cmd_valid ? cmd_q : INST_NOP;
  assign fetch_err = (state_q == StErr);
  assign inst_cnt  = inst_cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      cmd_q      <= INST_NOP;
      araddr_q   <= RESET_PC;
      ar_pend_q  <= 1'b0;
      tmo_q      <= '0;
      inst_cnt_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: state_q <= StAddr;
        StAddr: begin
          if (!ar_pend_q && !pc_ok) begin
            state_q <= StErr;
          end else begin
            araddr_q <= araddr;
            if (arready) begin
              state_q   <= StWait;
              ar_pend_q <= 1'b0;
              tmo_q     <= '0;
            end else begin
              ar_pend_q <= 1'b1;
            end
          end
        end
        StWait: begin
          if (rvalid) begin
            if (rresp == RESP_OKAY) begin
              cmd_q   <= rdata;
              state_q <= StExec;
            end else begin
              state_q <= StErr;
            end
          end else begin
            tmo_q <= tmo_next;
            if (tmo_hit) state_q <= StErr;
          end
        end
        StExec: begin
          inst_cnt_q <= inst_cnt_q + 32'd1;
          state_q    <= StAddr;
        end
        StErr:   state_q <= StErr;
        default: state_q <= StErr;
      endcase
    end
  end

endmodule

// File: tb/tb_ifu.sv
// Randomised bench for ifu: reactive memory and core PC, with a schedule-based model of
// which cycle each fetch phase lands on.
module tb_ifu;
  import ifu_pkg::*;

  localparam logic [31:0] RST_PC = 32'h8000_0000;
  localparam int          TMO    = 4;
  localparam int          MAXC   = 256;
  localparam int          MAXF   = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] pc = RST_PC;
  logic [31:0] rdata = '0;
  logic [1:0]  rresp = '0;
  logic        arready = 1'b0;
  logic        rvalid = 1'b0;
  logic [31:0] cmd, araddr, inst_cnt;
  logic        cmd_valid, pc_wen, arvalid, rready, fetch_err;

  ifu #(.RESET_PC(RST_PC), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .pc(pc), .cmd(cmd), .cmd_valid(cmd_valid), .pc_wen(pc_wen),
    .arvalid(arvalid), .araddr(araddr), .arready(arready), .rvalid(rvalid), .rdata(rdata),
    .rresp(rresp), .rready(rready), .fetch_err(fetch_err), .inst_cnt(inst_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Per-fetch plan: address stall, data stall, response, and the PC the core moves to.
  int          pa[MAXF];
  int          pr[MAXF];
  logic [1:0]  presp[MAXF];
  logic [31:0] npc[MAXF];
  logic [31:0] pc0;

  logic        e_arv[MAXC], e_rrdy[MAXC], e_cv[MAXC], e_err[MAXC];
  logic [31:0] e_addr[MAXC], e_cmd[MAXC], e_cnt[MAXC];

  int first_arv, first_exec, first_err, n_wen, n_arv;
  logic [31:0] first_cmd, last_cnt;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h8000_0000) return 32'h0050_0093;
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic plan_default(input logic [31:0] start);
    logic [31:0] p;
    p   = start;
    pc0 = start;
    for (int i = 0; i < MAXF; i++) begin
      pa[i] = 0; pr[i] = 0; presp[i] = RESP_OKAY;
      npc[i] = p + 32'd4;
      p = p + 32'd4;
    end
  endtask

  task automatic plan_random();
    logic [31:0] p;
    p   = {RST_PC[31:16], 16'($urandom)} & ~32'd3;
    pc0 = p;
    for (int i = 0; i < MAXF; i++) begin
      pa[i]    = $urandom_range(0, 3);
      pr[i]    = ($urandom_range(0, 14) == 0) ? $urandom_range(4, 8) : $urandom_range(0, 3);
      presp[i] = ($urandom_range(0, 19) == 0) ? 2'($urandom_range(1, 3)) : RESP_OKAY;
      if ($urandom_range(0, 29) == 0)     npc[i] = p + 32'd2;
      else if ($urandom_range(0, 3) == 0) npc[i] = {RST_PC[31:16], 16'($urandom)} & ~32'd3;
      else                                npc[i] = p + 32'd4;
      p = npc[i];
    end
  endtask

  // Walk the fetch plan: ADDR lasts pa+1 cycles, WAIT pr+1 cycles (or TMO on timeout),
  // then one EXEC cycle; the next ADDR follows immediately.
  task automatic build_model(input int ncyc);
    int c, w0, e, i;
    logic [31:0] p;
    bit done;
    for (int j = 0; j < MAXC; j++) begin
      e_arv[j] = 0; e_rrdy[j] = 0; e_cv[j] = 0; e_err[j] = 0;
      e_addr[j] = '0; e_cmd[j] = INST_NOP; e_cnt[j] = '0;
    end
    c = 2; p = pc0; i = 0; done = 0;
    while (!done && c <= ncyc && i < MAXF) begin
      if (p[1:0] != 2'b00) begin
        for (int j = c + 1; j <= ncyc; j++) e_err[j] = 1;
        done = 1;
      end else begin
        for (int j = c; j <= c + pa[i] && j <= ncyc; j++) begin
          e_arv[j] = 1; e_addr[j] = p;
        end
        w0 = c + pa[i] + 1;
        if (pr[i] >= TMO) begin
          for (int j = w0; j < w0 + TMO && j <= ncyc; j++) e_rrdy[j] = 1;
          for (int j = w0 + TMO; j <= ncyc; j++) e_err[j] = 1;
          done = 1;
        end else begin
          for (int j = w0; j <= w0 + pr[i] && j <= ncyc; j++) e_rrdy[j] = 1;
          e = w0 + pr[i] + 1;
          if (presp[i] != RESP_OKAY) begin
            for (int j = e; j <= ncyc; j++) e_err[j] = 1;
            done = 1;
          end else begin
            if (e <= ncyc) begin
              e_cv[e] = 1; e_cmd[e] = mem_word(p);
            end
            for (int j = e + 1; j <= ncyc; j++) e_cnt[j] = e_cnt[j] + 32'd1;
            p = npc[i]; c = e + 1; i++;
          end
        end
      end
    end
  endtask

  task automatic run(input int ncyc, input bit mid_reset);
    int ar_cnt, rd_cnt, mi, fi;
    bit pend, last_wen;
    logic [31:0] maddr;
    build_model(ncyc);
    rst = 1'b0; arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = '0; pc = pc0;
    ar_cnt = 0; rd_cnt = 0; mi = 0; fi = 0; pend = 0; last_wen = 0; maddr = '0;
    first_arv = 0; first_exec = 0; first_err = 0; n_wen = 0; n_arv = 0;
    first_cmd = '0; last_cnt = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_cmd", cmd, INST_NOP);
    check("rst_cmd_valid", cmd_valid, 1'b0);
    check("rst_pc_wen", pc_wen, 1'b0);
    check("rst_arvalid", arvalid, 1'b0);
    check("rst_rready", rready, 1'b0);
    check("rst_araddr", araddr, RST_PC);
    check("rst_fetch_err", fetch_err, 1'b0);
    check("rst_inst_cnt", inst_cnt, 32'd0);
    @(posedge clk);
    #1 rst = 1'b1;
    for (int k = 1; k <= ncyc; k++) begin
      if (k > 1) begin
        @(posedge clk);
        #1;
        if (last_wen) begin
          pc = npc[fi];
          fi++;
        end
      end
      @(negedge clk);
      check($sformatf("arvalid@%0d", k), arvalid, e_arv[k]);
      if (e_arv[k]) check($sformatf("araddr@%0d", k), araddr, e_addr[k]);
      check($sformatf("rready@%0d", k), rready, e_rrdy[k]);
      check($sformatf("cmd_valid@%0d", k), cmd_valid, e_cv[k]);
      check($sformatf("pc_wen@%0d", k), pc_wen, e_cv[k]);
      check($sformatf("cmd@%0d", k), cmd, e_cmd[k]);
      check($sformatf("fetch_err@%0d", k), fetch_err, e_err[k]);
      check($sformatf("inst_cnt@%0d", k), inst_cnt, e_cnt[k]);
      if (arvalid && first_arv == 0) first_arv = k;
      if (cmd_valid && first_exec == 0) begin
        first_exec = k; first_cmd = cmd;
      end
      if (fetch_err && first_err == 0) first_err = k;
      n_wen += int'(pc_wen);
      n_arv += int'(arvalid);
      last_cnt = inst_cnt;
      last_wen = pc_wen;
      // Reactive memory: spurious or late rvalid whenever the IFU is not accepting data.
      arready = ($urandom_range(0, 3) == 0);
      rvalid = 1'b0; rresp = 2'($urandom); rdata = $urandom;
      if (rready && pend) begin
        if (rd_cnt >= pr[mi]) begin
          rvalid = 1'b1; rdata = mem_word(maddr); rresp = presp[mi];
          pend = 0; mi++;
        end else begin
          rd_cnt++;
        end
      end else if (!rready) begin
        if (pend) begin
          if (rd_cnt >= pr[mi]) begin
            rvalid = 1'b1; rdata = mem_word(maddr); rresp = RESP_OKAY;
          end
          rd_cnt++;
        end else if ($urandom_range(0, 3) == 0) begin
          rvalid = 1'b1;
        end
      end
      if (arvalid) begin
        arready = 1'b0;
        if (ar_cnt >= pa[mi]) begin
          arready = 1'b1; pend = 1; rd_cnt = 0; maddr = araddr; ar_cnt = 0;
        end else begin
          ar_cnt++;
        end
      end
      if (mid_reset && k == ncyc) begin
        #2 rst = 1'b0;
        #1;
        check("midrst_arvalid", arvalid, 1'b0);
        check("midrst_rready", rready, 1'b0);
        check("midrst_cmd_valid", cmd_valid, 1'b0);
        check("midrst_pc_wen", pc_wen, 1'b0);
        check("midrst_fetch_err", fetch_err, 1'b0);
        check("midrst_cmd", cmd, INST_NOP);
        check("midrst_inst_cnt", inst_cnt, 32'd0);
      end
    end
  endtask

  initial begin
    // Zero-wait fetch of 0x00500093 at the reset PC.
    plan_default(RST_PC);
    run(6, 0);
    check("zw_first_arvalid", first_arv, 2);
    check("zw_exec_cycle", first_exec, 4);
    check("zw_cmd", first_cmd, 32'h0050_0093);
    check("zw_inst_cnt", last_cnt, 32'd1);

    // Stalled address and data phases: eight cycles later than zero-wait.
    plan_default(RST_PC);
    pa[0] = 5; pr[0] = 3; npc[0] = 32'h8000_0100;
    run(13, 0);
    check("slow_exec_cycle", first_exec, 12);
    check("slow_pc_wen_pulses", n_wen, 1);

    // Error response on the second fetch.
    plan_default(RST_PC);
    presp[1] = 2'b10;
    run(15, 0);
    check("resp_err_cycle", first_err, 7);
    check("resp_err_arvalids", n_arv, 2);
    check("resp_err_inst_cnt", last_cnt, 32'd1);

    // Misaligned PC never issues a request.
    plan_default(32'h8000_0002);
    run(10, 0);
    check("misal_err_cycle", first_err, 3);
    check("misal_arvalids", n_arv, 0);

    // Timeout: no data inside TMO WAIT cycles, late data ignored.
    plan_default(RST_PC);
    pr[0] = 9;
    run(20, 0);
    check("tmo_err_cycle", first_err, 7);
    check("tmo_inst_cnt", last_cnt, 32'd0);
    check("tmo_arvalids", n_arv, 1);

    // Reset pulled in the middle of WAIT, then a clean restart.
    plan_default(RST_PC);
    pr[0] = 3;
    run(4, 1);
    plan_default(RST_PC);
    run(8, 0);
    check("restart_first_arvalid", first_arv, 2);

    for (int s = 0; s < 25; s++) begin
      plan_random();
      run(120, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
